// File: rtl/retry_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retry_rr_arbiter_if : requester/downstream bundle of the retry RR arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface retry_rr_arbiter_if #(
   parameter type DATA_T  = logic,
   parameter int  NUM_REQ = 4,
   parameter int  ID_SIZE = 3
);
   localparam int IDX_W = $clog2(NUM_REQ);

   DATA_T              data_i [NUM_REQ];
   logic [NUM_REQ-1:0] valid_i;
   logic [NUM_REQ-1:0] ready_o;
   DATA_T              data_o;
   logic [IDX_W-1:0]   req_idx_o;
   logic               valid_o;
   logic               ready_i;
   logic               lock_i;
   logic               done_i;
   logic [ID_SIZE-1:0] inflight_o;
   logic               err_o;

   modport slave (
      input  data_i, valid_i, ready_i, lock_i, done_i,
      output ready_o, data_o, req_idx_o, valid_o, inflight_o, err_o
   );

   modport master (
      output data_i, valid_i, ready_i, lock_i, done_i,
      input  ready_o, data_o, req_idx_o, valid_o, inflight_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/retry_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retry_rr_arbiter : zero-latency round-robin arbiter feeding a retry pair,  |
// | with optional ID-space credit limit (macro RETRY_ARB_CREDIT_EN).           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module retry_rr_arbiter #(
   parameter type DATA_T  = logic,
   parameter int  NUM_REQ = 4,
   parameter int  ID_SIZE = 3
) (
   input wire                clk_i,
   input wire                rst_ni,
   retry_rr_arbiter_if.slave bus
);
   localparam int               IDX_W        = $clog2(NUM_REQ);
   localparam int               MAX_INFLIGHT = 2 ** (ID_SIZE - 1);
   localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [IDX_W-1:0]   r_gnt;
   logic [IDX_W-1:0]   w_gnt_nxt;
   logic [IDX_W-1:0]   w_pick;
   logic               w_any;
   logic [IDX_W-1:0]   w_gnt;
   logic               w_valid;
   logic               w_xfer;
   logic               w_credit_ok;
   logic [NUM_REQ-1:0] w_ready;

   // Highest offset first so the lowest offset from the pointer wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (bus.valid_i[(int'(r_ptr) + off) % NUM_REQ]) begin
            w_any  = 1'b1;
            w_pick = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ptr_nxt   = r_ptr;
      w_valid     = 1'b0;
      w_gnt       = '0;
      case (r_state)
         S_HOLD: begin
            // A requester that withdraws silently releases its hold.
            w_gnt   = r_gnt;
            w_valid = bus.valid_i[r_gnt];
            if (!w_valid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            if (!bus.lock_i && w_credit_ok && w_any) begin
               w_valid = 1'b1;
               w_gnt   = w_pick;
            end
         end
      endcase
      w_xfer = w_valid & bus.ready_i;
      if (w_xfer) begin
         w_state_nxt = S_IDLE;
         w_ptr_nxt   = (w_gnt == C_LAST_IDX) ? '0 : w_gnt + 1'b1;
      end else if (w_valid) begin
         w_state_nxt = S_HOLD;
         w_gnt_nxt   = w_gnt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_ready = '0;
      if (w_valid) begin
         w_ready[w_gnt] = bus.ready_i;
      end
   end

   assign bus.ready_o   = w_ready;
   assign bus.valid_o   = w_valid;
   assign bus.req_idx_o = w_valid ? w_gnt : '0;
   assign bus.data_o    = bus.data_i[w_gnt];

`ifdef RETRY_ARB_CREDIT_EN
   logic [ID_SIZE-1:0] r_cnt;
   logic               r_err;

   // A hold never exists at full count, so the limit only gates fresh grants.
   assign w_credit_ok = (r_cnt < ID_SIZE'(MAX_INFLIGHT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         case ({w_xfer, bus.done_i})
            2'b10: r_cnt <= r_cnt + 1'b1;
            2'b01: begin
               if (r_cnt == '0) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign bus.inflight_o = r_cnt;
   assign bus.err_o      = r_err;
`else
   wire w_unused_done = bus.done_i;

   assign w_credit_ok    = 1'b1;
   assign bus.inflight_o = '0;
   assign bus.err_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retry_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_retry_rr_arbiter : vector table + hand sequences for retry_rr_arbiter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_retry_rr_arbiter;
   localparam int N = 4;
   typedef logic [7:0] data_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   retry_rr_arbiter_if #(.DATA_T(data_t), .NUM_REQ(N), .ID_SIZE(3)) bus ();

   retry_rr_arbiter #(.DATA_T(data_t), .NUM_REQ(N), .ID_SIZE(3)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [3:0] valid;
      logic       ready;
      logic       lock;
      logic       done;
      logic       exp_v;
      logic [1:0] exp_idx;
      logic [3:0] exp_rdy;
      logic [2:0] exp_infl;
   } vec_t;

   vec_t vecs [12];
   vec_t sb_q [$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic r, input logic l, input logic d);
      @(negedge clk);
      bus.valid_i = v;
      bus.ready_i = r;
      bus.lock_i  = l;
      bus.done_i  = d;
      #1;
   endtask

   task automatic expect_out(input string nm, input logic ev, input logic [1:0] ei,
                             input logic [3:0] er, input logic [2:0] einf, input logic ee);
`ifndef RETRY_ARB_CREDIT_EN
      einf = 3'd0;
      ee   = 1'b0;
`endif
      chk({nm, "_valid"}, 32'(bus.valid_o), 32'(ev));
      chk({nm, "_idx"}, 32'(bus.req_idx_o), ev ? 32'(ei) : 32'd0);
      chk({nm, "_ready"}, 32'(bus.ready_o), 32'(er));
      if (ev) begin
         chk({nm, "_data"}, 32'(bus.data_o), 32'(8'hA0 + 8'(ei)));
      end
      chk({nm, "_infl"}, 32'(bus.inflight_o), 32'(einf));
      chk({nm, "_err"}, 32'(bus.err_o), 32'(ee));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      bus.valid_i = '0;
      bus.ready_i = 1'b0;
      bus.lock_i  = 1'b0;
      bus.done_i  = 1'b0;
      #2;
      expect_out("reset", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t e;
      for (int k = 0; k < N; k++) begin
         bus.data_i[k] = 8'hA0 + 8'(k);
      end
      //           valid    rdy   lck   done  exp_v idx    rdy_o    infl
      vecs[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 3'd0};
      vecs[1]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 3'd1};
      vecs[2]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 3'd1};
      vecs[3]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 3'd1};
      vecs[4]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 3'd1};
      vecs[5]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd1};
      vecs[6]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd1};
      vecs[7]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 3'd1};
      vecs[8]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 3'd1};
      vecs[9]  = '{4'b1010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 3'd2};
      vecs[10] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd2};
      vecs[11] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 3'd2};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].valid, vecs[i].ready, vecs[i].lock, vecs[i].done);
         sb_q.push_back(vecs[i]);
         e = sb_q.pop_front();
         expect_out($sformatf("vec%0d", i), e.exp_v, e.exp_idx, e.exp_rdy, e.exp_infl, 1'b0);
      end

      // Pointer 1 here; a withdrawn held request releases without error.
      drive(4'b0100, 1'b0, 1'b0, 1'b0);
      expect_out("drop_hold", 1'b1, 2'd2, 4'b0000, 3'd3, 1'b0);
      drive(4'b0000, 1'b0, 1'b0, 1'b0);
      expect_out("drop_rel", 1'b0, 2'd0, 4'b0000, 3'd3, 1'b0);
      drive(4'b1001, 1'b1, 1'b0, 1'b0);
      expect_out("drop_next", 1'b1, 2'd3, 4'b1000, 3'd3, 1'b0);

`ifdef RETRY_ARB_CREDIT_EN
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      expect_out("full_block", 1'b0, 2'd0, 4'b0000, 3'd4, 1'b0);
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      expect_out("full_done", 1'b0, 2'd0, 4'b0000, 3'd4, 1'b0);
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      expect_out("credit_grant", 1'b1, 2'd0, 4'b0001, 3'd3, 1'b0);
      drive(4'b1111, 1'b1, 1'b0, 1'b0);
      expect_out("full_again", 1'b0, 2'd0, 4'b0000, 3'd4, 1'b0);

      do_reset();
      drive(4'b0000, 1'b0, 1'b0, 1'b1);
      expect_out("underflow", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
      drive(4'b0000, 1'b0, 1'b0, 1'b0);
      expect_out("err_set", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1);
      drive(4'b0010, 1'b1, 1'b0, 1'b0);
      expect_out("err_sticky", 1'b1, 2'd1, 4'b0010, 3'd0, 1'b1);
`else
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      expect_out("nocred0", 1'b1, 2'd0, 4'b0001, 3'd0, 1'b0);
      for (int i = 1; i < 6; i++) begin
         drive(4'b1111, 1'b1, 1'b0, 1'b1);
         expect_out($sformatf("nocred%0d", i), 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 3'd0, 1'b0);
      end
`endif

      // Reset while a grant is held must drop it; pointer returns to 0.
      do_reset();
      drive(4'b0010, 1'b0, 1'b0, 1'b0);
      expect_out("pre_rst_hold", 1'b1, 2'd1, 4'b0000, 3'd0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      drive(4'b1100, 1'b1, 1'b0, 1'b0);
      expect_out("post_rst", 1'b1, 2'd2, 4'b0100, 3'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
